uart_rx_frame_ctrl: RTL and testbench

//  Framing controller on the UART receive byte stream (valid/ready, FIFO-backed read buffer).

---
 rtl/uart_frame_pkg.sv | 29 ++
 rtl/uart_rx_frame_ctrl_if.sv | 42 ++++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_rx_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types for the UART RX framing controller:
// FSM states, error codes and a constant-width helper.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CHK  = 2'd2,
        ERR_TMO  = 2'd3
    } err_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream in, payload-stream out and status bundle
// of the framing controller.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  frame_ok;
    logic                  frame_err;
    logic [1:0]            err_code;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_last,
        output frame_ok,
        output frame_err,
        output err_code
    );

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_last,
        input  frame_ok,
        input  frame_err,
        input  err_code
    );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port,
// one asynchronous read port.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX framing controller: SYNC/LEN/payload/CHK capture, verified drain.
// Optional inter-byte timeout enabled by UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MAX_LEN     = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE   = 8'hA5,
    parameter int                    TIMEOUT_CYC = 1302080
) (
    input logic                clk,
    input logic                rst,
    uart_rx_frame_ctrl_if.slave bus
);

    localparam int IW = clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1;
    localparam logic [DATA_WIDTH-1:0] LEN_MAX = DATA_WIDTH'(MAX_LEN);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_len;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_rd_idx;
    logic [IW-1:0]         w_len_m1;
    logic [DATA_WIDTH-1:0] r_chk;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  r_frame_ok;
    logic                  r_frame_err;
    err_t                  r_err_code;
    err_t                  w_err_code;
    logic                  w_ok;
    logic                  w_err;
    logic                  w_we;
    logic                  w_take;
    logic                  w_s_ready;
    logic                  w_acc;
    logic                  w_drain;
    logic                  w_last_rd;

    // Draining holds off the RX FIFO; reset also forces ready low.
    assign w_drain   = (r_state == ST_DRAIN);
    assign w_s_ready = ~w_drain & ~rst;
    assign w_acc     = bus.s_valid & w_s_ready;
    assign w_take    = w_drain & bus.m_ready;
    assign w_len_m1  = r_len - IDX_ONE;
    assign w_last_rd = (r_rd_idx == w_len_m1);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] GAP_TC = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_ONE = TW'(1);

    logic [TW-1:0] r_gap;
    logic          w_in_frame;
    logic          w_tmo;

    assign w_in_frame = (r_state == ST_LEN) ||
                        (r_state == ST_PAYLOAD) ||
                        (r_state == ST_CHK);
    // A byte accepted in the terminal cycle suppresses the timeout.
    assign w_tmo = w_in_frame & ~w_acc & (r_gap == GAP_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (w_acc || !w_in_frame) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + GAP_ONE;
        end
    end
`endif

    always_comb begin
        w_next     = r_state;
        w_ok       = 1'b0;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        w_we       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc && bus.s_data == SYNC_BYTE) begin
                    w_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_acc) begin
                    if (bus.s_data == '0 || bus.s_data > LEN_MAX) begin
                        w_next     = ST_IDLE;
                        w_err      = 1'b1;
                        w_err_code = ERR_LEN;
                    end else begin
                        w_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_acc) begin
                    w_we = 1'b1;
                    if (r_idx == w_len_m1) begin
                        w_next = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (w_acc) begin
                    if (bus.s_data == r_chk) begin
                        w_next = ST_DRAIN;
                        w_ok   = 1'b1;
                    end else begin
                        w_next     = ST_IDLE;
                        w_err      = 1'b1;
                        w_err_code = ERR_CHK;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_take && w_last_rd) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        if (w_tmo) begin
            w_next     = ST_IDLE;
            w_err      = 1'b1;
            w_err_code = ERR_TMO;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_rd_idx    <= '0;
            r_chk       <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_next;
            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
            if (r_state == ST_LEN && w_acc) begin
                r_len <= bus.s_data[IW-1:0];
                r_chk <= bus.s_data;
                r_idx <= '0;
            end
            if (w_we) begin
                r_chk <= r_chk ^ bus.s_data;
                r_idx <= r_idx + IDX_ONE;
            end
            if (w_ok) begin
                r_rd_idx <= '0;
            end
            if (w_take) begin
                r_rd_idx <= r_rd_idx + IDX_ONE;
            end
        end
    end

    uart_frame_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MAX_LEN),
        .AW        (AW)
    ) u_buf (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_idx[AW-1:0]),
        .i_wdata(bus.s_data),
        .i_raddr(r_rd_idx[AW-1:0]),
        .o_rdata(w_rdata)
    );

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = w_drain;
    assign bus.m_data    = w_drain ? w_rdata : '0;
    assign bus.m_last    = w_drain & w_last_rd;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.frame_err = r_frame_err;
    assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random frames vs a frame-level model.
// Timeout scenarios follow UART_FRAME_TIMEOUT_EN.
module tb_uart_rx_frame_ctrl;

    typedef logic [7:0] bq_t[$];

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAXL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [1:0] exp_err = 2'd0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_frame_ctrl #(
        .DATA_WIDTH (8),
        .MAX_LEN    (MAXL),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pre);
        chk({pre, "_s_ready"}, 32'(bus.s_ready), 0);
        chk({pre, "_m_valid"}, 32'(bus.m_valid), 0);
        chk({pre, "_m_last"}, 32'(bus.m_last), 0);
        chk({pre, "_m_data"}, 32'(bus.m_data), 0);
        chk({pre, "_frame_ok"}, 32'(bus.frame_ok), 0);
        chk({pre, "_frame_err"}, 32'(bus.frame_err), 0);
        chk({pre, "_err_code"}, 32'(bus.err_code), 0);
    endtask

    task automatic do_reset(input string pre);
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        check_zero(pre);
        exp_err = 2'd0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("s_ready_wait", 32'(bus.s_ready), 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic recv(input bq_t exp, input int mode);
        bq_t  q;
        int   cyc;
        logic r;
        q = exp;
        cyc = 0;
        while (q.size() > 0 && cyc < 1000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.m_ready = r;
            chk("m_valid", 32'(bus.m_valid), 1);
            chk("s_ready_drain", 32'(bus.s_ready), 0);
            chk("m_data", 32'(bus.m_data), 32'(q[0]));
            chk("m_last", 32'(bus.m_last), 32'(q.size() == 1));
            if (r && bus.m_valid) void'(q.pop_front());
            @(negedge clk);
            cyc++;
        end
        if (q.size() > 0) chk("drain_budget", q.size(), 0);
        bus.m_ready = 1'b0;
        chk("m_valid_after", 32'(bus.m_valid), 0);
        chk("s_ready_after", 32'(bus.s_ready), 1);
        chk("frame_ok_pulse", 32'(bus.frame_ok), 0);
    endtask

    task automatic expect_ok(input bq_t pay, input int mode);
        chk("frame_ok", 32'(bus.frame_ok), 1);
        chk("frame_err_on_ok", 32'(bus.frame_err), 0);
        chk("err_code_hold", 32'(bus.err_code), 32'(exp_err));
        recv(pay, mode);
    endtask

    task automatic expect_err(input logic [1:0] code);
        exp_err = code;
        chk("frame_err", 32'(bus.frame_err), 1);
        chk("err_code", 32'(bus.err_code), 32'(code));
        chk("m_valid_on_err", 32'(bus.m_valid), 0);
        chk("s_ready_on_err", 32'(bus.s_ready), 1);
        @(negedge clk);
        chk("frame_err_pulse", 32'(bus.frame_err), 0);
        chk("err_code_hold", 32'(bus.err_code), 32'(code));
    endtask

    // Frame outcome follows from the framing rules, not from the DUT.
    task automatic run_frame(input logic [7:0] len, input bq_t pay,
                             input logic [7:0] flip, input int mode);
        logic [7:0] c;
        send_byte(SYNC);
        send_byte(len);
        if (len == 0 || len > MAXL) begin
            expect_err(2'd1);
        end else begin
            c = len;
            foreach (pay[i]) begin
                send_byte(pay[i]);
                c = c ^ pay[i];
            end
            send_byte(c ^ flip);
            if (flip == 8'h00) expect_ok(pay, mode);
            else expect_err(2'd2);
        end
    endtask

    task automatic rand_pay(input int len, output bq_t q);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t        p;
        logic [7:0] b;
        logic [7:0] len;
        int         kind;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(bus.s_ready), 1);

        p = {};
        p.push_back(8'h11);
        p.push_back(8'h22);
        p.push_back(8'h33);
        run_frame(8'h03, p, 8'h00, 0);

        run_frame(8'h03, p, 8'h07, 0);
        run_frame(8'h03, p, 8'h00, 2);

        send_byte(8'h00);
        send_byte(8'hFF);
        chk("junk_no_err", 32'(bus.frame_err), 0);
        chk("junk_s_ready", 32'(bus.s_ready), 1);
        p = {};
        run_frame(8'h00, p, 8'h00, 0);
        run_frame(8'h11, p, 8'h00, 0);

        rand_pay(16, p);
        p[5] = SYNC;
        p[15] = SYNC;
        run_frame(8'd16, p, 8'h00, 1);

`ifdef UART_FRAME_TIMEOUT_EN
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (99) @(negedge clk);
        chk("tmo_not_early", 32'(bus.frame_err), 0);
        @(negedge clk);
        expect_err(2'd3);
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (99) @(negedge clk);
        send_byte(8'h22);
        chk("tmo_byte_wins", 32'(bus.frame_err), 0);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22);
        p = {};
        p.push_back(8'h11);
        p.push_back(8'h22);
        expect_ok(p, 0);
`else
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (150) @(negedge clk);
        chk("stall_no_err", 32'(bus.frame_err), 0);
        send_byte(8'h22);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22);
        p = {};
        p.push_back(8'h11);
        p.push_back(8'h22);
        expect_ok(p, 0);
`endif

        send_byte(SYNC);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        do_reset("rst_payload");
        rand_pay(4, p);
        run_frame(8'h04, p, 8'h00, 0);

        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        send_byte(8'h0D);
        send_byte(8'h04 ^ 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h0D);
        bus.m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_reset("rst_drain");
        rand_pay(6, p);
        run_frame(8'h06, p, 8'h00, 2);

        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h5A;
                send_byte(b);
            end
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ?
                      8'h00 : 8'($urandom_range(17, 255));
                p = {};
                run_frame(len, p, 8'h00, 0);
            end else begin
                len = 8'($urandom_range(1, 16));
                rand_pay(int'(len), p);
                run_frame(len, p,
                          (kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                          $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
